sr_flag_bank: RTL and testbench
===============================

Name: sr_flag_bank

Overview:
Parametrised bank of WIDTH clocked set/reset flags. Each channel has its own S/R inputs, which can be passed through an optional input synchroniser. A selectable rule decides what happens when S and R are both asserted. The bank supports bulk parallel load, registered change pulses, and a saturating conflict counter. It is the clocked, multi-channel replacement for single-bit asynchronous SR storage, used for status/event flags in control logic.

Parameters:
WIDTH, 8, number of independent flag channels (1..64)
MODE, 0, conflict rule when S[i]&R[i]: 0 set-dominant, 1 reset-dominant, 2 toggle (JK), 3 hold
SYNC_STAGES, 0, flops per S/R bit ahead of flag logic (0 = direct; 2 or 3 for async sources)
CNT_W, 8, width of conflict counter
RST_VAL, {WIDTH{1'b0}}, Q value after reset

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  synchronous reset, active-high
EN  input  1  update enable for S/R path; 0 = flags hold (LOAD still honoured)
S  input  WIDTH  per-channel set request, level-sampled
R  input  WIDTH  per-channel reset request, level-sampled
LOAD  input  1  bulk load strobe
D  input  WIDTH  bulk load data
CNT_CLR  input  1  clear conflict counter
Q  output  WIDTH  flag state (registered)
QN  output  WIDTH  ~Q, registered alongside Q, never combinationally derived from Q
CHG  output  WIDTH  one-cycle pulse per channel whose Q changed on the previous edge
CONF_CNT  output  CNT_W  count of edges on which any enabled channel saw S&R, saturating

Behaviour:
- Only synchronous reset is used: no asynchronous set/reset paths and no posedge S/R sensitivity.
- Reset (RST=1 at edge): Q=RST_VAL, QN=~RST_VAL, CHG=0, CONF_CNT=0, synchroniser stages=0. Reset overrides LOAD, EN, CNT_CLR.
- Synchroniser: S and R each pass through SYNC_STAGES flops. Ss/Rs denote the synchronised values.
- Latency: S/R change -> Q update at edge SYNC_STAGES+1 after the change is sampled. SYNC_STAGES=0 gives an update at the first edge.
- Priority per edge: RST > LOAD > EN-gated S/R > hold.
- LOAD=1: Q<=D for all channels, regardless of EN and of Ss/Rs. No conflict is counted on that edge.
- EN=1, LOAD=0, per channel i:
  - Ss=1, Rs=0: Q=1
  - Ss=0, Rs=1: Q=0
  - Ss=0, Rs=0: hold
  - Ss=1, Rs=1: by MODE. 0: Q=1. 1: Q=0. 2: Q=~Q. 3: hold.
- EN=0, LOAD=0: Q holds. The synchroniser keeps shifting. Requests present while EN=0 are not queued.
- QN is always ~Q on every cycle, including after reset and after LOAD.
- CHG[i] = 1 for exactly the cycle after an edge where Q[i] changed, whether by S/R, LOAD, or toggle. A reset edge produces CHG=0.
- Conflict counter:
  - Increments by 1 on an edge with EN=1, LOAD=0, RST=0, and (Ss&Rs)!=0. This is one increment per edge, regardless of how many channels conflict.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - CNT_CLR=1 sets it to 0. If CNT_CLR and an increment condition occur on the same edge, the result is 0.
- Reset mid-sequence: requests in flight in the synchroniser are discarded. Flags recover only on fresh S/R after RST deasserts.

Decomposition:
- Package sr_flag_pkg holds:
  - enum sr_mode_e {SR_SET_DOM=0, SR_RST_DOM=1, SR_TOGGLE=2, SR_HOLD=3}, with MODE typed as sr_mode_e.
  - A function next_flag(q, s, r, mode) returning the per-bit next state, shared by the RTL and the scoreboard.
- Sub-module sr_flag_sync: generic SYNC_STAGES x N-bit synchronous-reset shift chain. At SYNC_STAGES=0 it is a pure wire. It is instantiated once for the concatenated {S,R}.
- The top module holds the flag register, CHG, and the conflict counter.

Test Plan:
- WIDTH=8, SYNC_STAGES=0, MODE=0, after reset: S=8'h05 for 1 cycle -> next cycle Q=8'h05, QN=8'hFA, CHG=8'h05; the following cycle CHG=0.
- MODE=0/1/2/3, Q=8'h0F, S=R=8'hFF for one cycle -> Q=8'hFF / 8'h00 / 8'hF0 / 8'h0F respectively; CONF_CNT=1 in each case.
- LOAD=1, D=8'hA5, S=8'hFF on the same edge -> Q=8'hA5, CONF_CNT unchanged; with EN=0 and S=8'hFF, no LOAD -> Q holds.
- SYNC_STAGES=2: S[3] pulsed at cycle 0 -> Q[3] rises at edge 3, not earlier; assert RST at cycle 1 -> Q=RST_VAL and the pulse is lost.
- CNT_W=3, S=R=8'h01 held for 10 cycles -> CONF_CNT climbs to 7 and stays there; CNT_CLR with conflict still present -> 0 on that edge, 1 on the next.
- RST asserted together with LOAD and CNT_CLR -> Q=RST_VAL, CHG=0, CONF_CNT=0 on the next cycle.

Source files
------------

// File: rtl/sr_flag_pkg.sv
// Shared types and per-bit next-state rule for the clocked set/reset flag bank.
package sr_flag_pkg;

    typedef enum logic [1:0] {
        SR_SET_DOM = 2'd0,
        SR_RST_DOM = 2'd1,
        SR_TOGGLE  = 2'd2,
        SR_HOLD    = 2'd3
    } sr_mode_e;

    // The mode only matters when set and reset are requested together.
    function automatic logic next_flag(input logic q, input logic s, input logic r,
                                       input sr_mode_e mode);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                case (mode)
                    SR_SET_DOM: nxt = 1'b1;
                    SR_RST_DOM: nxt = 1'b0;
                    SR_TOGGLE:  nxt = ~q;
                    default:    nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_flag_sync.sv
// Generic N-bit shift chain of STAGES synchronous-reset flops; a plain wire at STAGES=0.
module sr_flag_sync #(
    parameter int STAGES = 0,
    parameter int N      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_direct
            assign dout = din;
        end else begin : g_chain
            logic [N-1:0] stage [STAGES];

            // NOTE: the chain is reset so requests in flight are dropped, not replayed after reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < STAGES; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of WIDTH clocked set/reset flags with bulk load, change pulses and a
// saturating conflict counter.
module sr_flag_bank
    import sr_flag_pkg::*;
#(
    parameter int             WIDTH       = 8,
    parameter sr_mode_e       MODE        = SR_SET_DOM,
    parameter int             SYNC_STAGES = 0,
    parameter int             CNT_W       = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             CNT_CLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic [WIDTH-1:0] CHG,
    output logic [CNT_W-1:0] CONF_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2*WIDTH-1:0] sr_sync;
    logic [WIDTH-1:0]   s_sync;
    logic [WIDTH-1:0]   r_sync;
    logic [WIDTH-1:0]   q_next;
    logic               conflict;

    sr_flag_sync #(
        .STAGES (SYNC_STAGES),
        .N      (2 * WIDTH)
    ) u_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  ({S, R}),
        .dout (sr_sync)
    );

    assign s_sync = sr_sync[2*WIDTH-1:WIDTH];
    assign r_sync = sr_sync[WIDTH-1:0];

    // NOTE: q_next is defaulted before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        q_next   = Q;
        conflict = 1'b0;
        if (LOAD) begin
            q_next = D;
        end else if (EN) begin
            conflict = |(s_sync & r_sync);
            for (int i = 0; i < WIDTH; i++) begin
                q_next[i] = next_flag(Q[i], s_sync[i], r_sync[i], MODE);
            end
        end
    end

    // QN is registered from q_next rather than inverted from Q, so it is a true flop output.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q        <= RST_VAL;
            QN       <= ~RST_VAL;
            CHG      <= '0;
            CONF_CNT <= '0;
        end else begin
            Q   <= q_next;
            QN  <= ~q_next;
            CHG <= q_next ^ Q;
            if (CNT_CLR) begin
                CONF_CNT <= '0;
            end else if (conflict && (CONF_CNT != CNT_MAX)) begin
                CONF_CNT <= CONF_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sr_flag_bank.sv
// Self-checking bench: six differently-configured banks share one stimulus bus
// and are compared against a behavioural model of the flag rules.
module tb_sr_flag_bank;
    import sr_flag_pkg::*;

    localparam int NI = 6;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic       cnt_clr;
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] d;

    logic [7:0] q_o   [NI];
    logic [7:0] qn_o  [NI];
    logic [7:0] chg_o [NI];
    logic [7:0] cnt_w [NI-1];
    logic [2:0] cnt_sat;

    // Instance configuration: mode, synchroniser depth, counter ceiling, reset value.
    int         k_mode   [NI] = '{0, 1, 2, 3, 0, 0};
    int         k_stages [NI] = '{0, 0, 0, 0, 2, 0};
    int         k_max    [NI] = '{255, 255, 255, 255, 255, 7};
    logic [7:0] k_rst    [NI] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00};

    // Behavioural model state.
    logic [7:0] m_q   [NI];
    logic [7:0] m_chg [NI];
    int         m_cnt [NI];
    logic [7:0] m_ps  [NI][2];
    logic [7:0] m_pr  [NI][2];

    int total = 0;
    int bad   = 0;

    sr_flag_bank #(.WIDTH(8), .MODE(SR_SET_DOM), .SYNC_STAGES(0), .CNT_W(8)) u_m0 (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .R(r), .LOAD(load), .D(d), .CNT_CLR(cnt_clr),
        .Q(q_o[0]), .QN(qn_o[0]), .CHG(chg_o[0]), .CONF_CNT(cnt_w[0]));
    sr_flag_bank #(.WIDTH(8), .MODE(SR_RST_DOM), .SYNC_STAGES(0), .CNT_W(8)) u_m1 (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .R(r), .LOAD(load), .D(d), .CNT_CLR(cnt_clr),
        .Q(q_o[1]), .QN(qn_o[1]), .CHG(chg_o[1]), .CONF_CNT(cnt_w[1]));
    sr_flag_bank #(.WIDTH(8), .MODE(SR_TOGGLE), .SYNC_STAGES(0), .CNT_W(8)) u_m2 (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .R(r), .LOAD(load), .D(d), .CNT_CLR(cnt_clr),
        .Q(q_o[2]), .QN(qn_o[2]), .CHG(chg_o[2]), .CONF_CNT(cnt_w[2]));
    sr_flag_bank #(.WIDTH(8), .MODE(SR_HOLD), .SYNC_STAGES(0), .CNT_W(8)) u_m3 (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .R(r), .LOAD(load), .D(d), .CNT_CLR(cnt_clr),
        .Q(q_o[3]), .QN(qn_o[3]), .CHG(chg_o[3]), .CONF_CNT(cnt_w[3]));
    sr_flag_bank #(.WIDTH(8), .MODE(SR_SET_DOM), .SYNC_STAGES(2), .CNT_W(8),
                   .RST_VAL(8'h81)) u_sync (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .R(r), .LOAD(load), .D(d), .CNT_CLR(cnt_clr),
        .Q(q_o[4]), .QN(qn_o[4]), .CHG(chg_o[4]), .CONF_CNT(cnt_w[4]));
    sr_flag_bank #(.WIDTH(8), .MODE(SR_SET_DOM), .SYNC_STAGES(0), .CNT_W(3)) u_sat (
        .CLK(clk), .RST(rst), .EN(en), .S(s), .R(r), .LOAD(load), .D(d), .CNT_CLR(cnt_clr),
        .Q(q_o[5]), .QN(qn_o[5]), .CHG(chg_o[5]), .CONF_CNT(cnt_sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int get_cnt(input int k);
        return (k == NI - 1) ? int'(cnt_sat) : int'(cnt_w[k]);
    endfunction

    // Reference model: updated at each rising edge from the inputs driven on the previous falling edge.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            logic [7:0] ss, rs, both, on_both, nq;
            if (rst) begin
                m_q[k]   = k_rst[k];
                m_chg[k] = 8'h00;
                m_cnt[k] = 0;
                for (int j = 0; j < 2; j++) begin
                    m_ps[k][j] = 8'h00;
                    m_pr[k][j] = 8'h00;
                end
            end else begin
                ss = (k_stages[k] == 0) ? s : m_ps[k][k_stages[k]-1];
                rs = (k_stages[k] == 0) ? r : m_pr[k][k_stages[k]-1];
                both = ss & rs;
                case (k_mode[k])
                    0:       on_both = 8'hFF;
                    1:       on_both = 8'h00;
                    2:       on_both = ~m_q[k];
                    default: on_both = m_q[k];
                endcase
                if (load)
                    nq = d;
                else if (en)
                    nq = (m_q[k] & ~(ss | rs)) | (ss & ~rs) | (both & on_both);
                else
                    nq = m_q[k];
                if (cnt_clr)
                    m_cnt[k] = 0;
                else if (en && !load && both != 8'h00 && m_cnt[k] < k_max[k])
                    m_cnt[k] = m_cnt[k] + 1;
                m_chg[k] = nq ^ m_q[k];
                m_q[k]   = nq;
                m_ps[k][1] = m_ps[k][0];
                m_pr[k][1] = m_pr[k][0];
                m_ps[k][0] = s;
                m_pr[k][0] = r;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        s = 8'h00; r = 8'h00; d = 8'h00;
        load = 1'b0; cnt_clr = 1'b0; en = 1'b1;
    endtask

    // Reset wins over LOAD, EN and CNT_CLR all asserted on the same edges.
    task automatic test_reset();
        rst = 1'b1; load = 1'b1; cnt_clr = 1'b1; en = 1'b1;
        d = 8'hFF; s = 8'hFF; r = 8'hFF;
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < NI; k++) begin
            total++;
            if (q_o[k] !== k_rst[k] || qn_o[k] !== ~k_rst[k] || chg_o[k] !== 8'h00
                || get_cnt(k) !== 0) begin
                bad++;
                $display("FAIL reset k=%0d q=%h qn=%h chg=%h cnt=%0d want q=%h qn=%h chg=00 cnt=0",
                         k, q_o[k], qn_o[k], chg_o[k], get_cnt(k), k_rst[k], ~k_rst[k]);
            end
        end
    endtask

    task automatic test_basic_set();
        s = 8'h05;
        tick();
        s = 8'h00;
        total++;
        if (q_o[0] !== 8'h05) begin
            bad++; $display("FAIL basic_q got=%h want=05", q_o[0]);
        end
        total++;
        if (qn_o[0] !== 8'hFA) begin
            bad++; $display("FAIL basic_qn got=%h want=FA", qn_o[0]);
        end
        total++;
        if (chg_o[0] !== 8'h05) begin
            bad++; $display("FAIL basic_chg got=%h want=05", chg_o[0]);
        end
        tick();
        total++;
        if (chg_o[0] !== 8'h00 || q_o[0] !== 8'h05) begin
            bad++; $display("FAIL basic_chg_clear chg=%h q=%h want chg=00 q=05", chg_o[0], q_o[0]);
        end
    endtask

    task automatic test_conflict_modes();
        logic [7:0] want [4];
        want = '{8'hFF, 8'h00, 8'hF0, 8'h0F};
        rst = 1'b1; tick(); rst = 1'b0;
        load = 1'b1; d = 8'h0F; tick(); load = 1'b0;
        s = 8'hFF; r = 8'hFF; tick();
        s = 8'h00; r = 8'h00;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== want[k] || qn_o[k] !== ~want[k] || get_cnt(k) !== 1) begin
                bad++;
                $display("FAIL conflict_mode%0d q=%h qn=%h cnt=%0d want q=%h cnt=1",
                         k, q_o[k], qn_o[k], get_cnt(k), want[k]);
            end
        end
        total++;
        if (chg_o[2] !== 8'hFF) begin
            bad++; $display("FAIL toggle_chg got=%h want=FF", chg_o[2]);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; d = 8'hA5; s = 8'hFF; r = 8'hFF; en = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if (q_o[0] !== 8'hA5 || qn_o[0] !== 8'h5A || get_cnt(0) !== 1) begin
            bad++;
            $display("FAIL load q=%h qn=%h cnt=%0d want q=A5 qn=5A cnt=1", q_o[0], qn_o[0], get_cnt(0));
        end
        en = 1'b0; s = 8'hFF; r = 8'h00;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'hA5 || chg_o[k] !== 8'h00) begin
                bad++;
                $display("FAIL en_hold k=%0d q=%h chg=%h want q=A5 chg=00", k, q_o[k], chg_o[k]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_sync_latency();
        logic [7:0] want [3];
        want = '{8'h81, 8'h81, 8'h89};
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        s = 8'h08;
        for (int e = 0; e < 3; e++) begin
            tick();
            s = 8'h00;
            total++;
            if (q_o[4] !== want[e]) begin
                bad++; $display("FAIL sync_edge%0d q=%h want=%h", e + 1, q_o[4], want[e]);
            end
        end
        s = 8'h08;
        tick();
        s = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 4; e++) begin
            total++;
            if (q_o[4] !== 8'h81 || chg_o[4] !== 8'h00) begin
                bad++; $display("FAIL sync_lost e=%0d q=%h chg=%h want q=81 chg=00", e, q_o[4], chg_o[4]);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1; tick(); rst = 1'b0;
        s = 8'h01; r = 8'h01; en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (get_cnt(5) !== ((i < 7) ? i : 7)) begin
                bad++; $display("FAIL sat_cnt i=%0d got=%0d want=%0d", i, get_cnt(5), (i < 7) ? i : 7);
            end
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        total++;
        if (get_cnt(5) !== 0) begin
            bad++; $display("FAIL sat_clr got=%0d want=0", get_cnt(5));
        end
        tick();
        total++;
        if (get_cnt(5) !== 1) begin
            bad++; $display("FAIL sat_after_clr got=%0d want=1", get_cnt(5));
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            s       = 8'($urandom);
            r       = 8'($urandom);
            d       = 8'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            load    = ($urandom_range(0, 7) == 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 31) == 0);
            tick();
            for (int k = 0; k < NI; k++) begin
                total++;
                if (q_o[k] !== m_q[k] || qn_o[k] !== ~m_q[k] || chg_o[k] !== m_chg[k]
                    || get_cnt(k) !== m_cnt[k]) begin
                    bad++;
                    $display("FAIL random n=%0d k=%0d q=%h qn=%h chg=%h cnt=%0d want q=%h chg=%h cnt=%0d",
                             n, k, q_o[k], qn_o[k], chg_o[k], get_cnt(k), m_q[k], m_chg[k], m_cnt[k]);
                end
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_set();
        test_conflict_modes();
        test_load_priority();
        test_sync_latency();
        test_saturate();
        test_random();
        s = 8'h03; r = 8'h03;
        tick();
        tick();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
